// File: rtl/tcon_pkg.sv
// Shared types for the transfer-controller word buffer.
// TCON_WORD_BUFFER_PARITY_EN adds a stored parity bit to each entry.
package tcon_pkg;

    localparam int TCON_WIDTH     = 8;
    localparam int TCON_BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } tcon_buf_state_t;

    typedef struct packed {
        logic                  sel;
        logic [TCON_WIDTH-1:0] sel_word;
        logic [TCON_WIDTH-1:0] pass_word;
`ifdef TCON_WORD_BUFFER_PARITY_EN
        logic                  parity;
`endif
    } tcon_entry_t;

endpackage

// File: rtl/tcon_buf_ctrl.sv
// Pointer, occupancy and overflow control for the word buffer.
// Tells the top when and from where to reload the registered head.
module tcon_buf_ctrl
    import tcon_pkg::*;
#(
    parameter int DEPTH = TCON_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     push,
    output logic                     pop,
    output logic                     load_head,
    output logic                     head_from_in,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_next,
    output logic [$clog2(DEPTH):0]   count,
    output tcon_buf_state_t          state,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    tcon_buf_state_t state_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_nxt;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign push      = in_valid && in_ready && !rst;
    assign pop       = out_valid && out_ready && !rst;
    assign rd_next   = rd_ptr + AW'(pop);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Head comes straight from the input when nothing older survives the pop.
    always_comb begin
        head_from_in = (count == '0) || (count == (AW+1)'(1) && pop);
        load_head    = (push && count == '0) || (pop && count_nxt != '0);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_EMPTY:
                if (push) state_nxt = ST_PARTIAL;
            ST_PARTIAL:
                if (push && !pop && count == LAST)
                    state_nxt = ST_FULL;
                else if (pop && !push && count == (AW+1)'(1))
                    state_nxt = ST_EMPTY;
            ST_FULL:
                if (pop) state_nxt = ST_PARTIAL;
            default:
                state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            rd_ptr <= rd_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (in_valid && !in_ready) drop_err <= 1'b1;
        end
    end

endmodule

// File: rtl/tcon_word_buffer.sv
// FIFO buffer for transfer-controller results with a registered head.
// TCON_WORD_BUFFER_PARITY_EN adds out_parity.
module tcon_word_buffer
    import tcon_pkg::*;
#(
    parameter int WIDTH = TCON_WIDTH,
    parameter int DEPTH = TCON_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sel,
    input  logic [WIDTH-1:0]         in_sel_word,
    input  logic [WIDTH-1:0]         in_pass_word,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_data,
    output logic                     out_sel,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
`ifdef TCON_WORD_BUFFER_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic            push;
    logic            pop;
    logic            load_head;
    logic            head_from_in;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_next;
    tcon_buf_state_t state;
    tcon_entry_t     wr_entry;
    tcon_entry_t     head;
    tcon_entry_t     mem [DEPTH];

    tcon_buf_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .push        (push),
        .pop         (pop),
        .load_head   (load_head),
        .head_from_in(head_from_in),
        .wr_ptr      (wr_ptr),
        .rd_next     (rd_next),
        .count       (count),
        .state       (state),
        .drop_err    (drop_err)
    );

    always_comb begin
        wr_entry           = '0;
        wr_entry.sel       = in_sel;
        wr_entry.sel_word  = in_sel_word;
        wr_entry.pass_word = in_pass_word;
`ifdef TCON_WORD_BUFFER_PARITY_EN
        wr_entry.parity    = ^{in_sel, in_sel_word, in_pass_word};
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Head register holds its value while empty.
    always_ff @(posedge clk) begin
        if (rst)
            head <= '0;
        else if (load_head)
            head <= head_from_in ? wr_entry : mem[rd_next];
    end

    assign out_data = {head.sel_word, head.pass_word};
    assign out_sel  = head.sel;
`ifdef TCON_WORD_BUFFER_PARITY_EN
    assign out_parity = head.parity;
`endif

endmodule

// File: tb/tb_tcon_word_buffer.sv
// Directed self-checking bench for tcon_word_buffer.
// Parity checks compile in with TCON_WORD_BUFFER_PARITY_EN.
module tb_tcon_word_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sel;
    logic [7:0]  in_sel_word;
    logic [7:0]  in_pass_word;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sel;
    logic [2:0]  count;
    logic        drop_err;
`ifdef TCON_WORD_BUFFER_PARITY_EN
    logic        out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcon_word_buffer #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sel      (in_sel),
        .in_sel_word (in_sel_word),
        .in_pass_word(in_pass_word),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .count       (count),
        .drop_err    (drop_err)
`ifdef TCON_WORD_BUFFER_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s,
                         input logic [7:0] sw, input logic [7:0] pw);
        in_valid     = v;
        in_sel       = s;
        in_sel_word  = sw;
        in_pass_word = pw;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);

        drive(1'b1, 1'b1, 8'hA5, 8'h3C);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("pass_valid", 32'(out_valid), 32'd1);
        chk("pass_data", 32'(out_data), 32'hA53C);
        chk("pass_sel", 32'(out_sel), 32'd1);
        chk("pass_count", 32'(count), 32'd1);
`ifdef TCON_WORD_BUFFER_PARITY_EN
        chk("pass_parity", 32'(out_parity), 32'd1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_count", 32'(count), 32'd0);
        chk("pop_valid", 32'(out_valid), 32'd0);
        chk("empty_hold_data", 32'(out_data), 32'hA53C);
        chk("empty_hold_sel", 32'(out_sel), 32'd1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i), 8'(8'h10 + i), 8'(8'h20 + i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head", 32'(out_data), 32'h1020);
        chk("fill_head_sel", 32'(out_sel), 32'd0);
        chk("fill_no_drop", 32'(drop_err), 32'd0);
        drive(1'b1, 1'b1, 8'h55, 8'h55);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("overflow_drop", 32'(drop_err), 32'd1);
        chk("overflow_count", 32'(count), 32'd4);

        drive(1'b1, 1'b1, 8'h66, 8'h66);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("full_pp_count", 32'(count), 32'd3);
        chk("full_pp_head", 32'(out_data), 32'h1121);
        chk("drop_sticky", 32'(drop_err), 32'd1);
        tick();
        chk("drain_head2", 32'(out_data), 32'h1222);
        tick();
        chk("drain_head3", 32'(out_data), 32'h1323);
        chk("drain_sel3", 32'(out_sel), 32'd1);
        tick();
        chk("drain_empty", 32'(count), 32'd0);
        chk("drain_hold", 32'(out_data), 32'h1323);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_drop_clear", 32'(drop_err), 32'd0);
        chk("rst2_out_data", 32'(out_data), 32'h0);

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'h01, 8'(i));
            tick();
            chk("wrap_data", 32'(out_data), 32'h0100 + 32'(i));
            chk("wrap_valid", 32'(out_valid), 32'd1);
            chk("wrap_count", 32'(count), 32'd1);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("wrap_end_count", 32'(count), 32'd0);
        chk("wrap_drop", 32'(drop_err), 32'd0);
        chk("wrap_hold", 32'(out_data), 32'h0109);

        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h31, 8'h41);
        tick();
        drive(1'b1, 1'b1, 8'h59, 8'h26);
        tick();
        chk("sim_pre_count", 32'(count), 32'd2);
        chk("sim_pre_head", 32'(out_data), 32'h3141);
        drive(1'b1, 1'b0, 8'h77, 8'h77);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("sim_count", 32'(count), 32'd2);
        chk("sim_head", 32'(out_data), 32'h5926);
        chk("sim_sel", 32'(out_sel), 32'd1);

        drive(1'b1, 1'b1, 8'h88, 8'h99);
        tick();
        chk("mid_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hEE, 8'hEE);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_data", 32'(out_data), 32'h0);
`ifdef TCON_WORD_BUFFER_PARITY_EN
        chk("mid_parity", 32'(out_parity), 32'd0);
`endif
        tick();
        chk("mid_push_ignored", 32'(count), 32'd0);
        chk("mid_still_invalid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcon_word_buffer.md
TCON_WORD_BUFFER -- requirements
Module: tcon_word_buffer

Interface
REQ-001 Parameter: WIDTH, 8, bit width of each transfer-controller word (selected word and pass-through word).
REQ-002 Parameter: DEPTH, 4, FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream offers one transfer-controller result.
REQ-006 Port: in_sel  input  1  bank-select value that produced in_sel_word (1 = bank A, 0 = bank B).
REQ-007 Port: in_sel_word  input  WIDTH  muxed word from the transfer controller.
REQ-008 Port: in_pass_word  input  WIDTH  pass-through word from the transfer controller.
REQ-009 Port: in_ready  output  1  buffer can accept a transfer this cycle.
REQ-010 Port: out_valid  output  1  head entry is available.
REQ-011 Port: out_ready  input  1  downstream accepts the head entry.
REQ-012 Port: out_data  output  2*WIDTH  head entry, {sel_word, pass_word}.
REQ-013 Port: out_sel  output  1  in_sel stored with the head entry.
REQ-014 Port: count  output  log2(DEPTH)+1  number of occupied entries.
REQ-015 Port: drop_err  output  1  sticky flag; set when in_valid is high while in_ready is low.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH); it is combinational from registered state only.
REQ-018 out_valid SHALL equal (count != 0); out_data and out_sel SHALL be driven from the registered head entry.
REQ-019 Latency: an entry pushed in cycle N SHALL be visible at the outputs in cycle N+1 if the FIFO was empty; there is no combinational in-to-out path.
REQ-020 Order is strict FIFO; a stored entry is never modified or reordered.
REQ-021 Read and write pointers have log2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 When full, a simultaneous pop and push is NOT accepted, because in_ready is low; the offered word is refused.
REQ-024 When empty, out_data and out_sel SHALL hold their last value, and out_valid is 0.
REQ-025 drop_err SHALL be set in the cycle after in_valid=1 with in_ready=0, and stays set until rst.
REQ-026 Control state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
REQ-027 State transitions: EMPTY->PARTIAL on push; PARTIAL->FULL on push-only reaching DEPTH; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop-only reaching 0.

Reset
REQ-028 On rst: count=0, pointers=0, out_valid=0, in_ready=1, drop_err=0, out_data=0, out_sel=0.
REQ-029 rst SHALL take effect mid-operation and discard all stored entries; a push asserted in the reset cycle is ignored.

Configuration
REQ-030 With TCON_WORD_BUFFER_PARITY_EN defined: an extra output out_parity (1 bit) SHALL equal the even parity (XOR) of {out_sel, out_data}, computed at push and stored with the entry.
REQ-031 Without TCON_WORD_BUFFER_PARITY_EN: the out_parity port and its storage SHALL be absent.

Structure
REQ-032 A shared package tcon_pkg SHALL hold TCON_WIDTH (8), TCON_BUF_DEPTH (4), the state enum type tcon_buf_state_t, and the entry struct tcon_entry_t {sel, sel_word, pass_word[, parity]}.
REQ-033 One sub-module, tcon_buf_ctrl, SHALL own the pointers, count, state and drop_err; the top level SHALL own the storage array.

Verification
REQ-034 Reset: assert rst for 2 cycles -> count=0, out_valid=0, in_ready=1, drop_err=0.
REQ-035 Single pass: push {sel=1, sel_word=0xA5, pass_word=0x3C} -> the next cycle shows out_valid=1, out_data=0xA53C, out_sel=1.
REQ-036 Fill: push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th push -> refused, drop_err=1 the next cycle.
REQ-037 Wrap: 10 back-to-back pushes with out_ready=1 -> outputs appear in order 0x0100..0x0109, count stays at or below 1, drop_err=0.
REQ-038 Simultaneous: with count=2, push and pop in the same cycle -> count=2, and the new head is the second entry.
REQ-039 Mid-reset: with count=3, assert rst together with in_valid -> the next cycle count=0, out_valid=0; with parity enabled, out_parity=0.
